// File: rtl/ram_arb_pkg.sv
// ---------------------------------------------------------------------------
// ram_arb_pkg
// Shared types and helpers for the two-port program/data RAM arbiter.
//   state_t     : arbiter ownership state (IDLE, OWN0, OWN1)
//   PORT_CPU    : index of the CPU control path (port 0)
//   PORT_LOADER : index of the programming/debug loader (port 1)
//   rr_next()   : round-robin owner selection used when leaving IDLE
// ---------------------------------------------------------------------------
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam logic PORT_CPU    = 1'b0;
  localparam logic PORT_LOADER = 1'b1;

  // A lone requester wins outright; on a tie the port that was not served
  // last wins, so neither side can starve the other.
  function automatic state_t rr_next(input logic req0, input logic req1,
                                     input logic last_served);
    state_t nxt;
    if (req0 && req1) nxt = (last_served == PORT_LOADER) ? OWN0 : OWN1;
    else if (req0)    nxt = OWN0;
    else if (req1)    nxt = OWN1;
    else              nxt = IDLE;
    return nxt;
  endfunction

endpackage

// File: rtl/ram_arbiter.sv
// ---------------------------------------------------------------------------
// ram_arbiter
// Shares one single-port synchronous RAM between the CPU (port 0) and the
// loader (port 1). Round-robin grants, optional locked bursts bounded by
// LOCK_LIMIT consecutive grants while the other port waits.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   reqN/lockN/weN/addrN/wdataN: port N request, lock, write, address, data
//   gntN                       : port N access issued to the RAM this cycle
//   rvalidN/rdataN             : port N read data (one cycle after gntN read)
//   ram_we/ram_address/ram_data_in : RAM command, owned by the arbiter
//   ram_data_out               : RAM registered read data
// ---------------------------------------------------------------------------
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 4,
  parameter int DATA_WIDTH    = 8,
  parameter int LOCK_LIMIT    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req0,
  input  logic                     lock0,
  input  logic                     we0,
  input  logic [ADDRESS_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0]    wdata0,
  output logic                     gnt0,
  output logic                     rvalid0,
  output logic [DATA_WIDTH-1:0]    rdata0,
  input  logic                     req1,
  input  logic                     lock1,
  input  logic                     we1,
  input  logic [ADDRESS_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0]    wdata1,
  output logic                     gnt1,
  output logic                     rvalid1,
  output logic [DATA_WIDTH-1:0]    rdata1,
  output logic                     ram_we,
  output logic [ADDRESS_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0]    ram_data_in,
  input  logic [DATA_WIDTH-1:0]    ram_data_out
);

  localparam logic [7:0] LOCK_MAX = 8'(LOCK_LIMIT - 1);

  state_t     state_q, state_d;
  logic       last_q, last_d;
  logic [7:0] lock_cnt_q, lock_cnt_d;
  logic       rvalid0_q, rvalid1_q;

  // Owner-relative view of the two ports, so one set of rules serves both.
  logic   sel1;
  logic   own_req, own_lock, oth_req, own_gnt;
  state_t oth_state;

  always_comb begin
    // NOTE: every combinational output gets a default before the case so no
    // path leaves a signal unassigned and no latch is inferred.
    gnt0        = 1'b0;
    gnt1        = 1'b0;
    ram_we      = 1'b0;
    ram_address = '0;
    ram_data_in = '0;
    state_d     = state_q;
    last_d      = last_q;
    lock_cnt_d  = 8'd0;

    sel1      = (state_q == OWN1);
    own_req   = sel1 ? req1  : req0;
    own_lock  = sel1 ? lock1 : lock0;
    oth_req   = sel1 ? req0  : req1;
    oth_state = sel1 ? OWN0  : OWN1;
    own_gnt   = 1'b0;

    case (state_q)
      IDLE: state_d = rr_next(req0, req1, last_q);

      OWN0, OWN1: begin
        own_gnt     = own_req;
        gnt0        = !sel1 && req0;
        gnt1        = sel1 && req1;
        ram_address = sel1 ? addr1 : addr0;
        ram_data_in = sel1 ? wdata1 : wdata0;
        ram_we      = sel1 ? (we1 && req1) : (we0 && req0);

        // Lock holds ownership until the waiting port has seen LOCK_LIMIT
        // consecutive grants go the other way.
        if (own_req && own_lock && !(oth_req && lock_cnt_q == LOCK_MAX)) begin
          state_d = state_q;
        end else if (oth_req) begin
          state_d = oth_state;
          last_d  = sel1;
        end else if (own_req) begin
          state_d = state_q;
        end else begin
          state_d = IDLE;
          last_d  = sel1;
        end

        // Counter only runs while the owner keeps the RAM and the other port
        // is waiting; any other outcome clears it.
        if (state_d == state_q && oth_req) begin
          if (own_gnt) lock_cnt_d = (lock_cnt_q == LOCK_MAX) ? LOCK_MAX : lock_cnt_q + 8'd1;
          else         lock_cnt_d = lock_cnt_q;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_q     <= PORT_LOADER;
      lock_cnt_q <= 8'd0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      lock_cnt_q <= lock_cnt_d;
      rvalid0_q  <= gnt0 && !we0;
      rvalid1_q  <= gnt1 && !we1;
    end
  end

  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign rdata0  = ram_data_out;
  assign rdata1  = ram_data_out;

endmodule

// File: tb/tb_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ram_arbiter
// Directed bench for ram_arbiter (LOCK_LIMIT=4) with a behavioural 16x8
// synchronous RAM. Stimulus pushes expected read data into per-port queues
// when a read grant is seen; a negedge monitor pops and compares whenever a
// port presents rvalid.
// ---------------------------------------------------------------------------
module tb_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, lock0, we0, req1, lock1, we1;
  logic [3:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       gnt0, gnt1, rvalid0, rvalid1;
  logic [7:0] rdata0, rdata1;
  logic       ram_we;
  logic [3:0] ram_address;
  logic [7:0] ram_data_in;
  logic [7:0] ram_data_out;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;

  logic [7:0] mem [16];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (ram_we) mem[ram_address] <= ram_data_in;
    ram_data_out <= mem[ram_address];
  end

  ram_arbiter #(.ADDRESS_WIDTH(4), .DATA_WIDTH(8), .LOCK_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .lock0(lock0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .lock1(lock1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .ram_we(ram_we), .ram_address(ram_address), .ram_data_in(ram_data_in),
    .ram_data_out(ram_data_out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic port, input logic [7:0] data);
    exp_t e;
    e.data = data;
    e.cyc  = cyc + 1;
    if (port) q1.push_back(e);
    else      q0.push_back(e);
  endtask

  // Monitor: rvalid is registered, so mid-cycle sampling is stable.
  always @(negedge clk) begin
    if (rvalid0 === 1'b1) begin
      if (q0.size() == 0) check("rvalid0_spurious", 32'(rvalid0), 0);
      else begin
        e0 = q0.pop_front();
        check("rdata0", 32'(rdata0), 32'(e0.data));
        check("rvalid0_latency", cyc, e0.cyc);
      end
    end
    if (rvalid1 === 1'b1) begin
      if (q1.size() == 0) check("rvalid1_spurious", 32'(rvalid1), 0);
      else begin
        e1 = q1.pop_front();
        check("rdata1", 32'(rdata1), 32'(e1.data));
        check("rvalid1_latency", cyc, e1.cyc);
      end
    end
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'(i * 3);
    mem[1]  = 8'h11;
    mem[2]  = 8'h22;
    mem[14] = 8'h0A;

    rst_n = 1'b0;
    req0 = 0; lock0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; lock1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt0", 32'(gnt0), 0);
    check("rst_gnt1", 32'(gnt1), 0);
    check("rst_rvalid0", 32'(rvalid0), 0);
    check("rst_rvalid1", 32'(rvalid1), 0);
    check("rst_ram_we", 32'(ram_we), 0);
    check("rst_ram_addr", 32'(ram_address), 0);
    rst_n = 1'b1;

    // Single read from port 0: request in cycle 1, grant in cycle 2
    tick(); req0 = 1; addr0 = 4'hE; #1;
    check("t1_idle_gnt0", 32'(gnt0), 0);
    tick();
    check("t1_gnt0", 32'(gnt0), 1);
    check("t1_gnt1", 32'(gnt1), 0);
    check("t1_addr", 32'(ram_address), 32'h0E);
    check("t1_we", 32'(ram_we), 0);
    push(1'b0, 8'h0A);
    tick(); req0 = 0; #1;
    check("t1_release_gnt0", 32'(gnt0), 0);

    // Reset lands while a port 1 read is in flight: its rvalid must not follow
    tick(); req1 = 1; we1 = 0; addr1 = 4'h2; #1;
    check("t5_idle_gnt1", 32'(gnt1), 0);
    tick();
    check("t5_gnt1", 32'(gnt1), 1);
    #2; rst_n = 1'b0; req1 = 0; #1;
    check("t5_rst_gnt1", 32'(gnt1), 0);
    tick();
    check("t5_rst_rvalid1", 32'(rvalid1), 0);
    tick();
    check("t5_rst_rvalid1_b", 32'(rvalid1), 0);
    rst_n = 1'b1;

    // Simultaneous reads: port 0 wins the first tie, then strict alternation
    tick(); req0 = 1; we0 = 0; addr0 = 4'h1; req1 = 1; we1 = 0; addr1 = 4'h2; #1;
    check("t2_idle_gnt0", 32'(gnt0), 0);
    check("t2_idle_gnt1", 32'(gnt1), 0);
    check("t2_idle_addr", 32'(ram_address), 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t2_rr_gnt0", 32'(gnt0), (i % 2 == 0) ? 1 : 0);
      check("t2_rr_gnt1", 32'(gnt1), (i % 2 == 1) ? 1 : 0);
      if (i % 2 == 0) push(1'b0, 8'h11);
      else            push(1'b1, 8'h22);
    end
    tick(); req0 = 0; req1 = 0; #1;
    check("t2_drop_gnt0", 32'(gnt0), 0);
    check("t2_drop_gnt1", 32'(gnt1), 0);

    // Locked write burst from port 1 while port 0 waits (LOCK_LIMIT=4)
    tick(); req1 = 1; lock1 = 1; we1 = 1; addr1 = 4'h3; wdata1 = 8'h55; #1;
    check("t3_idle_gnt1", 32'(gnt1), 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 0) begin req0 = 1; we0 = 0; addr0 = 4'h3; end
      #1;
      check("t3_lock_gnt1", 32'(gnt1), 1);
      check("t3_lock_gnt0", 32'(gnt0), 0);
      check("t3_lock_we", 32'(ram_we), 1);
      check("t3_lock_wdata", 32'(ram_data_in), 32'h55);
    end
    tick(); req1 = 0; lock1 = 0; we1 = 0; #1;
    check("t3_after_gnt0", 32'(gnt0), 1);
    check("t3_after_gnt1", 32'(gnt1), 0);
    push(1'b0, 8'h55);
    tick(); req0 = 0; #1;
    check("t3_drop_gnt0", 32'(gnt0), 0);

    // Write then read the same address on consecutive grants
    tick(); req0 = 1; we0 = 1; addr0 = 4'h7; wdata0 = 8'hA5; #1;
    check("t4_idle_gnt0", 32'(gnt0), 0);
    tick();
    check("t4_wr_gnt0", 32'(gnt0), 1);
    check("t4_wr_we", 32'(ram_we), 1);
    check("t4_wr_addr", 32'(ram_address), 32'h07);
    tick(); we0 = 0; #1;
    check("t4_rd_gnt0", 32'(gnt0), 1);
    check("t4_rd_we", 32'(ram_we), 0);
    check("t4_no_rvalid_after_wr", 32'(rvalid0), 0);
    push(1'b0, 8'hA5);
    tick(); req0 = 0; #1;
    check("t4_drop_gnt0", 32'(gnt0), 0);

    // Owner drops req mid-burst with lock held and the other port idle
    tick(); req1 = 1; lock1 = 1; we1 = 1; addr1 = 4'h5; wdata1 = 8'h66; #1;
    check("t6_idle_gnt1", 32'(gnt1), 0);
    tick();
    check("t6_burst_gnt1_a", 32'(gnt1), 1);
    tick();
    check("t6_burst_gnt1_b", 32'(gnt1), 1);
    tick(); req1 = 0; #1;
    check("t6_drop_gnt1", 32'(gnt1), 0);
    check("t6_drop_we", 32'(ram_we), 0);
    tick();
    check("t6_idle_gnt0", 32'(gnt0), 0);
    check("t6_idle_gnt1b", 32'(gnt1), 0);
    check("t6_idle_we", 32'(ram_we), 0);
    check("t6_idle_addr", 32'(ram_address), 0);

    repeat (3) tick();
    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
